// File: rtl/gate_test_sequencer.sv
// Start/busy/done sequencer for a two-input gate under test. Each run sweeps the
// four input vectors, compares the gate output with a latched truth table, and reports the result.
`timescale 1ns/1ps

module gate_test_sequencer #(
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_table,
  input  logic [3:0] num_passes,
  input  logic       gate_out,
  output logic       gate_in_a,
  output logic       gate_in_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [1:0] first_err_vec,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_pass_cnt;
  logic [3:0]       r_passes;
  logic [3:0]       r_tt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [5:0]       r_err;
  logic [1:0]       r_fev;
  logic             r_fv;

  logic       w_sample;
  logic       w_mismatch;
  logic       w_last;
  logic [5:0] w_err_next;

  assign w_sample   = (r_hold == HOLD_LAST);
  assign w_mismatch = (gate_out != r_tt[r_vec]);
  assign w_last     = (r_vec == 2'b11) && (r_pass_cnt == r_passes - 4'd1);
  // The final verdict must include a mismatch found on the very last sample.
  assign w_err_next = r_err + {5'd0, w_mismatch};

  // NOTE: non-blocking assignments throughout, so every decision below uses pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      // NOTE: the latched table and pass count are reset too, so no stale run configuration survives.
      r_state    <= S_IDLE;
      r_vec      <= 2'b00;
      r_hold     <= '0;
      r_pass_cnt <= 4'd0;
      r_passes   <= 4'd0;
      r_tt       <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 6'd0;
      r_fev      <= 2'b00;
      r_fv       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_tt       <= truth_table;
            r_passes   <= (num_passes == 4'd0) ? 4'd1 : num_passes;
            r_err      <= 6'd0;
            r_fev      <= 2'b00;
            r_fv       <= 1'b0;
            r_pass     <= 1'b0;
            r_vec      <= 2'b00;
            r_hold     <= '0;
            r_pass_cnt <= 4'd0;
            r_busy     <= 1'b1;
            r_state    <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_vec      <= 2'b00;
            r_hold     <= '0;
            r_pass_cnt <= 4'd0;
          end else if (w_sample) begin
            r_hold <= '0;
            r_vec  <= r_vec + 2'd1;
            if (w_mismatch) begin
              r_err <= w_err_next;
              if (!r_fv) begin
                r_fev <= r_vec;
                r_fv  <= 1'b1;
              end
            end
            if (r_vec == 2'b11) begin
              r_pass_cnt <= r_pass_cnt + 4'd1;
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= (w_err_next == 6'd0);
              r_pass_cnt <= 4'd0;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_in_a       = r_vec[1];
  assign gate_in_b       = r_vec[0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_vec   = r_fev;
  assign first_err_valid = r_fv;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: a table of complete runs against modelled gates,
// plus hand-written abort, mid-run interference, reset and start+abort sequences.
`timescale 1ns/1ps

module tb_gate_test_sequencer;

  localparam int H = 5;

  typedef enum logic [1:0] {GUT_OR, GUT_AND, GUT_STUCK0} gut_t;

  typedef struct {
    gut_t       gut;
    logic [3:0] tt;
    logic [3:0] np;
    int         exp_edges;
    int         exp_err;
    logic [1:0] exp_fev;
    logic       exp_fv;
    logic       exp_pass;
  } row_t;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] truth_table = 4'd0;
  logic [3:0] num_passes = 4'd0;
  logic       gate_out;
  logic       gate_in_a, gate_in_b, busy, done, pass, first_err_valid;
  logic [5:0] err_count;
  logic [1:0] first_err_vec;
  gut_t       gut_mode = GUT_OR;

  int n_checks = 0;
  int n_fail   = 0;
  row_t rows[7];

  gate_test_sequencer #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .start           (start),
    .abort           (abort),
    .truth_table     (truth_table),
    .num_passes      (num_passes),
    .gate_out        (gate_out),
    .gate_in_a       (gate_in_a),
    .gate_in_b       (gate_in_b),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_vec   (first_err_vec),
    .first_err_valid (first_err_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (gut_mode)
      GUT_OR:  gate_out = gate_in_a | gate_in_b;
      GUT_AND: gate_out = gate_in_a & gate_in_b;
      default: gate_out = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete run; when interfere is set, start/truth_table/num_passes are disturbed mid-run
  // and start is also raised while the sequencer sits in DONE.
  task automatic run_seq(input gut_t gut, input logic [3:0] tt, input logic [3:0] np,
                         input int exp_edges, input int exp_err, input logic [1:0] exp_fev,
                         input logic exp_fv, input logic exp_pass, input bit interfere,
                         input string tag);
    int edges;
    int vec_bad;
    bit seen;
    @(negedge clk);
    gut_mode    = gut;
    truth_table = tt;
    num_passes  = np;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_on_accept"}, busy, 1);
    check({tag, "_err_cleared"}, {err_count, first_err_valid}, 0);
    edges   = 0;
    vec_bad = 0;
    seen    = 1'b0;
    while (!seen && edges < 4 * H * 16 + 8) begin
      if (edges < exp_edges && {gate_in_a, gate_in_b} != 2'((edges / H) % 4)) vec_bad++;
      if (interfere) begin
        if (edges == 3) begin
          start       = 1'b1;
          truth_table = ~tt;
          num_passes  = 4'd5;
        end
        if (edges == 6) start = 1'b0;
      end
      tick();
      edges++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_latency"}, seen ? edges : -1, exp_edges);
    check({tag, "_vector_order"}, vec_bad, 0);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_inputs_idle"}, {gate_in_a, gate_in_b}, 0);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_first_err_valid"}, first_err_valid, exp_fv);
    check({tag, "_first_err_vec"}, first_err_vec, exp_fev);
    check({tag, "_pass"}, pass, exp_pass);
    if (interfere) start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_no_restart"}, busy, 0);
    check({tag, "_result_held"}, {pass, err_count}, {exp_pass, 6'(exp_err)});
    truth_table = tt;
  endtask

  task automatic run_abort(input logic [3:0] tt, input int k, input int exp_err,
                           input logic [1:0] exp_fev, input logic exp_fv, input string tag);
    int dcount;
    @(negedge clk);
    gut_mode    = GUT_OR;
    truth_table = tt;
    num_passes  = 4'd1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < k; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_inputs_idle"}, {gate_in_a, gate_in_b}, 0);
    check({tag, "_pass_low"}, pass, 0);
    check({tag, "_err_frozen"}, err_count, exp_err);
    check({tag, "_fev_frozen"}, {first_err_valid, first_err_vec}, {exp_fv, exp_fev});
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    check({tag, "_no_done_pulse"}, dcount, 0);
    check({tag, "_err_still_frozen"}, err_count, exp_err);
  endtask

  initial begin
    rows[0] = '{GUT_OR,     4'b1110, 4'd1,  20,  0, 2'b00, 1'b0, 1'b1};
    rows[1] = '{GUT_OR,     4'b1000, 4'd1,  20,  2, 2'b01, 1'b1, 1'b0};
    rows[2] = '{GUT_STUCK0, 4'b1110, 4'd3,  60,  9, 2'b01, 1'b1, 1'b0};
    rows[3] = '{GUT_STUCK0, 4'b1110, 4'd0,  20,  3, 2'b01, 1'b1, 1'b0};
    rows[4] = '{GUT_AND,    4'b1000, 4'd2,  40,  0, 2'b00, 1'b0, 1'b1};
    rows[5] = '{GUT_STUCK0, 4'b1111, 4'd15, 300, 60, 2'b00, 1'b1, 1'b0};
    rows[6] = '{GUT_OR,     4'b0110, 4'd1,  20,  1, 2'b11, 1'b1, 1'b0};

    #1;
    check("reset_outputs", {gate_in_a, gate_in_b, busy, done, pass, err_count,
                            first_err_vec, first_err_valid}, 0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_seq(rows[i].gut, rows[i].tt, rows[i].np, rows[i].exp_edges, rows[i].exp_err,
              rows[i].exp_fev, rows[i].exp_fv, rows[i].exp_pass, 1'b0, $sformatf("row%0d", i));
    end

    run_seq(GUT_OR, 4'b1110, 4'd1, 20, 0, 2'b00, 1'b0, 1'b1, 1'b1, "interfere");

    run_abort(4'b1110, 7, 0, 2'b00, 1'b0, "abort7");
    run_seq(GUT_OR, 4'b1110, 4'd1, 20, 0, 2'b00, 1'b0, 1'b1, 1'b0, "after_abort");
    run_abort(4'b1000, 12, 1, 2'b01, 1'b1, "abort12");

    // Asynchronous reset in the middle of a run that already has one mismatch.
    @(negedge clk);
    gut_mode    = GUT_STUCK0;
    truth_table = 4'b1110;
    num_passes  = 4'd1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("pre_reset_err", err_count, 1);
    #2 reset_L = 1'b0;
    #1;
    check("midrun_reset_outputs", {gate_in_a, gate_in_b, busy, done, pass, err_count,
                                   first_err_vec, first_err_valid}, 0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    repeat (25) begin
      tick();
      if (done || busy) check("reset_no_resume", {done, busy}, 0);
    end

    // start together with abort in IDLE must not start a run.
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("start_abort_busy", busy, 0);
    tick();
    check("start_abort_idle", {busy, gate_in_a, gate_in_b, done}, 0);
    start = 1'b0;
    abort = 1'b0;

    run_seq(GUT_OR, 4'b1110, 4'd1, 20, 0, 2'b00, 1'b0, 1'b1, 1'b0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
